// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash operation sequencer.
// Optional feature macro: SPI_FAST_READ_EN (fast read with dummy cycles).
package spi_flash_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_PROGRAM = 2'd1,
    OP_ERASE   = 2'd2,
    OP_STATUS  = 2'd3
  } op_code_e;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WREN_REQ  = 4'd1,
    ST_WREN_WAIT = 4'd2,
    ST_MAIN_REQ  = 4'd3,
    ST_MAIN_WAIT = 4'd4,
    ST_POLL_GAP  = 4'd5,
    ST_POLL_REQ  = 4'd6,
    ST_POLL_WAIT = 4'd7,
    ST_DONE      = 4'd8
  } state_e;

  localparam logic [7:0] CMD_WREN      = 8'h06;
  localparam logic [7:0] CMD_PP        = 8'h02;
  localparam logic [7:0] CMD_SE        = 8'h20;
  localparam logic [7:0] CMD_RDSR      = 8'h05;
  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  localparam int STATUS_WIP_BIT = 0;

  // Request fields presented to the SPI master controller (address bus
  // itself is derived from address_valid in the top).
  typedef struct packed {
    logic [7:0] command;
    logic       read_write_n;
    logic       address_valid;
    logic       dummy_valid;
    logic       data_valid;
    logic [2:0] dummy_cycles;
    logic [7:0] data_bytes;
  } req_fields_t;

  // Read-status access: used for both the STATUS op and every poll.
  localparam req_fields_t RDSR_FIELDS = '{
    command:       CMD_RDSR,
    read_write_n:  1'b1,
    address_valid: 1'b0,
    dummy_valid:   1'b0,
    data_valid:    1'b1,
    dummy_cycles:  3'd0,
    data_bytes:    8'd0
  };

endpackage

// File: rtl/spi_flash_sequencer_poll_timer.sv
// Poll gap down-counter and saturating poll counter for program/erase
// completion polling.
module spi_flash_poll_timer
  import spi_flash_pkg::*;
#(
  parameter int POLL_GAP   = 64,
  parameter int POLL_LIMIT = 1024
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_gap_load,
  input  logic i_gap_run,
  input  logic i_poll_clear,
  input  logic i_poll_inc,
  output logic o_gap_done,
  output logic o_poll_last
);

  localparam logic [15:0] GAP_LOAD = 16'(POLL_GAP - 1);
  localparam logic [15:0] LIMIT_M1 = 16'(POLL_LIMIT - 1);

  logic [15:0] r_gap_cnt;
  logic [15:0] r_poll_cnt;

  // Gap timer: loaded with gap-1 on entry, terminal count at zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_gap_cnt <= '0;
    end else if (i_gap_load) begin
      r_gap_cnt <= GAP_LOAD;
    end else if (i_gap_run && (r_gap_cnt != '0)) begin
      r_gap_cnt <= r_gap_cnt - 16'd1;
    end
  end

  // Poll counter: counts completed polls, saturating at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_poll_cnt <= '0;
    end else if (i_poll_clear) begin
      r_poll_cnt <= '0;
    end else if (i_poll_inc && (r_poll_cnt != 16'hFFFF)) begin
      r_poll_cnt <= r_poll_cnt + 16'd1;
    end
  end

  assign o_gap_done  = (r_gap_cnt == '0);
  // True while the poll in flight is the one that will reach the limit.
  assign o_poll_last = (r_poll_cnt >= LIMIT_M1);

endmodule

// File: rtl/spi_flash_sequencer.sv
// SPI flash operation sequencer: expands host operations into
// write-enable / main command / status-poll controller accesses.
// Optional feature macro: SPI_FAST_READ_EN (READ uses 0Bh + 8 dummy cycles).
//
// state      | meaning
// IDLE       | ready for a host operation
// WREN_REQ   | request write-enable access
// WREN_WAIT  | wait for write-enable completion
// MAIN_REQ   | request main command access
// MAIN_WAIT  | wait for main command completion
// POLL_GAP   | idle between status polls
// POLL_REQ   | request status poll
// POLL_WAIT  | wait for poll completion, decide on WIP bit
// DONE       | one-cycle completion report
module spi_flash_sequencer
  import spi_flash_pkg::*;
#(
  parameter int POLL_GAP   = 64,
  parameter int POLL_LIMIT = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_op_valid,
  output logic        o_op_ready,
  input  logic [1:0]  i_op_code,
  input  logic [23:0] i_op_address,
  input  logic [7:0]  i_op_length,
  output logic        o_op_done,
  output logic        o_op_error,
  output logic [7:0]  o_op_status,
  output logic        o_access_request,
  output logic        o_read_write_n,
  output logic [7:0]  o_command,
  output logic [31:0] o_address,
  output logic [1:0]  o_address_bytes,
  output logic        o_address_valid,
  output logic        o_dummy_valid,
  output logic        o_data_valid,
  output logic [2:0]  o_dummy_cycles,
  output logic [7:0]  o_data_bytes,
  input  logic        i_access_complete,
  input  logic        i_spi_rx_we,
  input  logic [7:0]  i_spi_rx_data
);

  localparam bit GAP_EN = (POLL_GAP != 0);

  state_e      r_state;
  state_e      w_state_next;
  op_code_e    r_op;
  logic [23:0] r_op_address;
  logic [7:0]  r_op_length;
  logic        r_error;
  logic [7:0]  r_op_status;

  logic        w_accept;
  logic        w_err_set;
  logic        w_gap_load;
  logic        w_gap_run;
  logic        w_poll_clear;
  logic        w_poll_inc;
  logic        w_gap_done;
  logic        w_poll_last;
  logic        w_wip;
  logic        w_capture;
  logic        w_is_pe;
  req_fields_t w_fields;

  spi_flash_poll_timer #(
    .POLL_GAP   (POLL_GAP),
    .POLL_LIMIT (POLL_LIMIT)
  ) u_poll_timer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_gap_load   (w_gap_load),
    .i_gap_run    (w_gap_run),
    .i_poll_clear (w_poll_clear),
    .i_poll_inc   (w_poll_inc),
    .o_gap_done   (w_gap_done),
    .o_poll_last  (w_poll_last)
  );

  assign w_accept = (r_state == ST_IDLE) && i_op_valid;
  assign w_is_pe  = (r_op == OP_PROGRAM) || (r_op == OP_ERASE);
  // A status byte arriving with the completion pulse is used directly.
  assign w_wip    = i_spi_rx_we ? i_spi_rx_data[STATUS_WIP_BIT]
                                : r_op_status[STATUS_WIP_BIT];
  assign w_capture = i_spi_rx_we &&
                     (((r_state == ST_MAIN_WAIT) && (r_op == OP_STATUS)) ||
                      (r_state == ST_POLL_WAIT));

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and timer controls.
  always_comb begin
    w_state_next = r_state;
    w_gap_load   = 1'b0;
    w_gap_run    = 1'b0;
    w_poll_clear = 1'b0;
    w_poll_inc   = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_op_valid) begin
          if ((i_op_code == OP_PROGRAM) || (i_op_code == OP_ERASE)) begin
            w_state_next = ST_WREN_REQ;
          end else begin
            w_state_next = ST_MAIN_REQ;
          end
        end
      end
      ST_WREN_REQ:  w_state_next = ST_WREN_WAIT;
      ST_WREN_WAIT: if (i_access_complete) w_state_next = ST_MAIN_REQ;
      ST_MAIN_REQ:  w_state_next = ST_MAIN_WAIT;
      ST_MAIN_WAIT: begin
        if (i_access_complete) begin
          if (w_is_pe) begin
            w_poll_clear = 1'b1;
            w_gap_load   = GAP_EN;
            w_state_next = GAP_EN ? ST_POLL_GAP : ST_POLL_REQ;
          end else begin
            w_state_next = ST_DONE;
          end
        end
      end
      ST_POLL_GAP: begin
        w_gap_run = 1'b1;
        if (w_gap_done) w_state_next = ST_POLL_REQ;
      end
      ST_POLL_REQ:  w_state_next = ST_POLL_WAIT;
      ST_POLL_WAIT: begin
        if (i_access_complete) begin
          w_poll_inc = 1'b1;
          if (!w_wip) begin
            w_state_next = ST_DONE;
          end else if (w_poll_last) begin
            w_err_set    = 1'b1;
            w_state_next = ST_DONE;
          end else begin
            w_gap_load   = GAP_EN;
            w_state_next = GAP_EN ? ST_POLL_GAP : ST_POLL_REQ;
          end
        end
      end
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Operation latch and error flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op         <= OP_READ;
      r_op_address <= '0;
      r_op_length  <= '0;
      r_error      <= 1'b0;
    end else if (w_accept) begin
      r_op         <= op_code_e'(i_op_code);
      r_op_address <= i_op_address;
      r_op_length  <= i_op_length;
      r_error      <= 1'b0;
    end else if (w_err_set) begin
      r_error      <= 1'b1;
    end
  end

  // Status byte capture, held until the next capture.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op_status <= '0;
    end else if (w_capture) begin
      r_op_status <= i_spi_rx_data;
    end
  end

  // Request field decode; fields stay stable for the whole REQ/WAIT pair.
  always_comb begin
    w_fields = '0;
    case (r_state)
      ST_WREN_REQ, ST_WREN_WAIT: w_fields.command = CMD_WREN;
      ST_MAIN_REQ, ST_MAIN_WAIT: begin
        case (r_op)
          OP_READ: begin
`ifdef SPI_FAST_READ_EN
            w_fields.command      = CMD_FAST_READ;
            w_fields.dummy_valid  = 1'b1;
            w_fields.dummy_cycles = 3'd7;
`else
            w_fields.command      = CMD_READ;
`endif
            w_fields.address_valid = 1'b1;
            w_fields.data_valid    = 1'b1;
            w_fields.read_write_n  = 1'b1;
            w_fields.data_bytes    = r_op_length;
          end
          OP_PROGRAM: begin
            w_fields.command       = CMD_PP;
            w_fields.address_valid = 1'b1;
            w_fields.data_valid    = 1'b1;
            w_fields.data_bytes    = r_op_length;
          end
          OP_ERASE: begin
            w_fields.command       = CMD_SE;
            w_fields.address_valid = 1'b1;
          end
          default: w_fields = RDSR_FIELDS;
        endcase
      end
      ST_POLL_REQ, ST_POLL_WAIT: w_fields = RDSR_FIELDS;
      default: ;
    endcase
  end

  assign o_op_ready       = (r_state == ST_IDLE) && !i_reset;
  assign o_op_done        = (r_state == ST_DONE);
  assign o_op_error       = (r_state == ST_DONE) && r_error;
  assign o_op_status      = r_op_status;
  assign o_access_request = (r_state == ST_WREN_REQ) || (r_state == ST_MAIN_REQ) ||
                            (r_state == ST_POLL_REQ);
  assign o_command        = w_fields.command;
  assign o_read_write_n   = w_fields.read_write_n;
  assign o_address_valid  = w_fields.address_valid;
  assign o_dummy_valid    = w_fields.dummy_valid;
  assign o_data_valid     = w_fields.data_valid;
  assign o_dummy_cycles   = w_fields.dummy_cycles;
  assign o_data_bytes     = w_fields.data_bytes;
  assign o_address        = w_fields.address_valid ? {8'h00, r_op_address} : 32'h0;
  assign o_address_bytes  = w_fields.address_valid ? 2'd2 : 2'd0;

endmodule

// File: doc/spi_flash_sequencer.md
# spi_flash_sequencer

Host-side operation sequencer placed directly upstream of the SPI master controller. Accepts one high-level flash operation at a time (read, page program, sector erase, read status). Expands each operation into the required sequence of controller accesses (write-enable, main command, status polling) by driving the controller's request fields and watching its completion pulse. Captures the status byte from the controller's receive-write port and reports completion and errors to the host.

## Interface
- POLL_GAP, 64: idle cycles between a poll's `access_complete` and the next poll request (0 legal).
- POLL_LIMIT, 1024: maximum status polls per program/erase before error (1..65535).
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- op_valid  in  1  host operation request.
- op_ready  out  1  sequencer idle, op accepted when op_valid&&op_ready.
- op_code  in  2  0=READ, 1=PROGRAM, 2=ERASE, 3=STATUS.
- op_address  in  24  flash byte address.
- op_length  in  8  data bytes minus one (READ/PROGRAM).
- op_done  out  1  one-cycle pulse, operation finished.
- op_error  out  1  valid with op_done: poll limit exhausted.
- op_status  out  8  last captured status byte, held until next capture.
- access_request  out  1  one-cycle pulse to controller.
- read_write_n  out  1  1=data phase reads, 0=data phase writes.
- command  out  8  SPI opcode.
- address  out  32  {8'h00, op_address}.
- address_bytes  out  2  address bytes minus one (always 2 when used).
- address_valid, dummy_valid, data_valid  out  1 each  phase enables.
- dummy_cycles  out  3  dummy cycles minus one.
- data_bytes  out  8  data bytes minus one.
- access_complete  in  1  one-cycle pulse, controller access finished.
- spi_rx_we  in  1  controller receive-byte strobe.
- spi_rx_data  in  8  controller receive byte.

## Operation
- States: IDLE, WREN_REQ, WREN_WAIT, MAIN_REQ, MAIN_WAIT, POLL_GAP, POLL_REQ, POLL_WAIT, DONE.
- IDLE: op_ready=1. On accept, latch op fields. PROGRAM/ERASE go to WREN_REQ. READ/STATUS go to MAIN_REQ.
- *_REQ states: pulse access_request for one cycle, then go to the matching *_WAIT state.
- *_WAIT states: hold all request fields stable until access_complete.
- WREN: command 8'h06, no address/dummy/data.
- MAIN field encoding:
  - READ: 8'h03, address, data read, data_bytes=op_length.
  - PROGRAM: 8'h02, address, data write (read_write_n=0), data_bytes=op_length.
  - ERASE: 8'h20, address, no data.
  - STATUS: 8'h05, data read, data_bytes=0.
- MAIN_WAIT exit on access_complete:
  - PROGRAM/ERASE go to POLL_GAP, clearing the poll counter.
  - READ goes to DONE.
  - STATUS goes to DONE, with the status byte captured.
- POLL_REQ: RDSR encoded exactly as STATUS.
- POLL_WAIT exit on access_complete; the poll counter increments here.
  - status bit0 clear: go to DONE, op_error=0.
  - bit0 set and counter==POLL_LIMIT: go to DONE, op_error=1.
  - otherwise: go to POLL_GAP.
- POLL_GAP: count POLL_GAP cycles, then go to POLL_REQ. With POLL_GAP=0, go straight to POLL_REQ.
- Status capture: op_status<=spi_rx_data on spi_rx_we, only in MAIN_WAIT (STATUS op) or POLL_WAIT.
- Same-cycle spi_rx_we and access_complete: the bit0 decision uses spi_rx_data directly (bypass).
- DONE: op_done=1 for one cycle, then IDLE.
- access_complete outside any *_WAIT state is ignored.
- Reset mid-operation: state returns to IDLE; any controller access in flight is abandoned.

## Timing
- Reset values:
  - op_ready=0 while reset asserted, 1 the cycle after release.
  - op_done, op_error, access_request, all *_valid, read_write_n: 0.
  - command, address, data_bytes, dummy_cycles, address_bytes, op_status: 0.
- Accept at cycle N: access_request pulses at N+1.
- access_complete at cycle M:
  - next request pulses at M+1 (WREN to MAIN; POLL_GAP=0).
  - with POLL_GAP=G>0, the next poll request pulses at M+G+1.
- op_done pulses at M+1 after the final access_complete.
- op_valid while busy is not accepted; the host holds it.
- Poll counter is 16 bits, saturating.

## Configuration
- SPI_FAST_READ_EN defined: READ uses 8'h0B with dummy_valid=1, dummy_cycles=7 (8 cycles).
- Undefined: READ uses 8'h03, dummy_valid=0.
- Other operations are identical in both builds.

## Structure
- Package spi_flash_pkg holds:
  - op_code enum.
  - state enum.
  - opcode constants (WREN 06, PP 02, SE 20, RDSR 05, READ 03, FAST_READ 0B).
  - STATUS_WIP_BIT=0.
- One sub-module, spi_flash_poll_timer: gap countdown plus saturating poll counter, with a limit-reached flag.

## Test plan
- READ addr 24'h123456, length 8'h0F: one access_request; command 03, address 32'h00123456, data_bytes 0F, read_write_n=1; op_done the cycle after access_complete.
- ERASE addr 24'h001000, WIP returned as 1,1,0 (POLL_GAP=4):
  - accesses in order: 06, 20, 05×3.
  - each poll request 5 cycles after the previous complete.
  - op_done with op_error=0, op_status=8'h00.
- PROGRAM, WIP stuck at 1, POLL_LIMIT=3: exactly 3 polls, then op_done with op_error=1, op_status=8'h01.
- STATUS op, spi_rx_we and access_complete in the same cycle with data 8'hA5: op_status=8'hA5, op_done next cycle.
- Reset asserted during PROGRAM MAIN_WAIT: next cycle all outputs at reset values; a new READ is accepted after release and runs normally.
- SPI_FAST_READ_EN build, READ length 0: command 0B, dummy_valid=1, dummy_cycles=7, data_bytes=0.
